// File: rtl/hermes_periph_mux_pkg.sv
// Shared types and helpers for the Hermes peripheral mux.
// State encoding for both packet FSMs plus header field geometry.
package HermesPeriphMuxPkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SIZE,
        PAYLOAD
    } state_t;

    // Default bit position of the channel index inside the header flit
    localparam int IDX_LSB_DEF = 16;

    // Channel-index field width; a single channel still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hermes_periph_fifo.sv
// Synchronous FIFO with combinational head and credit (not-full) output.
// Depth must be a power of two so the pointers wrap naturally.
module hermes_periph_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             credit_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full     = (count == FULL_CNT);
    assign empty_o  = (count == '0);
    assign credit_o = !full;
    assign do_rd    = rd_i && !empty_o;
    assign do_wr    = wr_i && (!full || do_rd);
    assign data_o   = mem[rd_ptr];

    // Storage array: written at the tail, never reset
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hermes_periph_mux.sv
// Hermes peripheral mux: N packet peripherals share one boundary port.
// Define HERMES_PERIPH_MUX_STATS_EN for per-channel packet/drop counters.
module hermes_periph_mux
    import HermesPeriphMuxPkg::*;
#(
    parameter int N_PERIPH     = 2,
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 4,
    parameter int IDX_LSB      = IDX_LSB_DEF,
    localparam int IDX_W       = idx_width(N_PERIPH)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N_PERIPH-1:0]                 release_i,
    input  logic [N_PERIPH-1:0]                 p_rx_i,
    output logic [N_PERIPH-1:0]                 p_credit_o,
    input  logic [N_PERIPH-1:0][FLIT_SIZE-1:0]  p_data_i,
    output logic [N_PERIPH-1:0]                 p_tx_o,
    input  logic [N_PERIPH-1:0]                 p_credit_i,
    output logic [N_PERIPH-1:0][FLIT_SIZE-1:0]  p_data_o,
    output logic                                noc_tx_o,
    input  logic                                noc_credit_i,
    output logic [FLIT_SIZE-1:0]                noc_data_o,
    input  logic                                noc_rx_i,
    output logic                                noc_credit_o,
    input  logic [FLIT_SIZE-1:0]                noc_data_i,
`ifdef HERMES_PERIPH_MUX_STATS_EN
    input  logic [IDX_W-1:0]                    stat_sel_i,
    output logic [31:0]                         stat_o,
`endif
    output logic                                drop_o
);
    localparam logic [IDX_W-1:0]     LAST_CH = IDX_W'(N_PERIPH - 1);
    localparam logic [FLIT_SIZE-1:0] ONE     = FLIT_SIZE'(1);

    state_t                 in_state;
    state_t                 out_state;
    logic [IDX_W-1:0]       in_grant;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_pick;
    logic                   rr_found;
    logic [N_PERIPH-1:0]    eligible;
    logic [FLIT_SIZE-1:0]   in_cnt;
    logic                   in_xfer;
    int                     rr_c;

    logic [FLIT_SIZE-1:0]   head;
    logic                   empty;
    logic                   fifo_credit;
    logic                   fifo_wr;
    logic                   pop;
    logic [FLIT_SIZE-1:0]   out_cnt;
    logic [IDX_W-1:0]       out_dst;
    logic                   out_fwd;
    logic [IDX_W-1:0]       hdr_idx;
    logic                   hdr_fwd;
    logic [IDX_W-1:0]       cur_dst;
    logic                   cur_fwd;

    // ---------------- peripheral -> mesh ----------------

    assign eligible = p_rx_i & release_i;

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_c     = 0;
        for (int k = 0; k < N_PERIPH; k++) begin
            rr_c = int'(rr_ptr) + k;
            if (rr_c >= N_PERIPH) begin
                rr_c = rr_c - N_PERIPH;
            end
            if (!rr_found && eligible[rr_c]) begin
                rr_found = 1'b1;
                rr_pick  = IDX_W'(rr_c);
            end
        end
    end

    // Granted channel is passed straight through to the mesh port
    always_comb begin
        noc_tx_o   = 1'b0;
        noc_data_o = '0;
        p_credit_o = '0;
        if (in_state != IDLE && !rst_i) begin
            noc_tx_o             = p_rx_i[in_grant];
            noc_data_o           = p_data_i[in_grant];
            p_credit_o[in_grant] = noc_credit_i;
        end
    end

    assign in_xfer = noc_tx_o && noc_credit_i;

    // Inbound packet FSM: grant, then count header/size/payload
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_state <= IDLE;
            in_grant <= '0;
            rr_ptr   <= '0;
            in_cnt   <= '0;
        end else begin
            unique case (in_state)
                IDLE: begin
                    if (rr_found) begin
                        in_grant <= rr_pick;
                        rr_ptr   <= (rr_pick == LAST_CH) ? '0 : rr_pick + 1'b1;
                        in_state <= HEADER;
                    end
                end
                HEADER: begin
                    if (in_xfer) begin
                        in_state <= SIZE;
                    end
                end
                SIZE: begin
                    if (in_xfer) begin
                        in_cnt   <= noc_data_o;
                        in_state <= (noc_data_o == '0) ? IDLE : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_xfer) begin
                        in_cnt <= in_cnt - 1'b1;
                        if (in_cnt == ONE) begin
                            in_state <= IDLE;
                        end
                    end
                end
                default: in_state <= IDLE;
            endcase
        end
    end

    // ---------------- mesh -> peripheral ----------------

    assign noc_credit_o = fifo_credit && !rst_i;
    assign fifo_wr      = noc_rx_i && noc_credit_o;

    hermes_periph_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_i     (fifo_wr),
        .data_i   (noc_data_i),
        .rd_i     (pop),
        .data_o   (head),
        .empty_o  (empty),
        .credit_o (fifo_credit)
    );

    // Destination is decoded live at the header, then held for the packet
    assign hdr_idx = head[IDX_LSB +: IDX_W];
    assign hdr_fwd = (int'(hdr_idx) < N_PERIPH) && release_i[hdr_idx];
    assign cur_dst = (out_state == IDLE) ? hdr_idx : out_dst;
    assign cur_fwd = (out_state == IDLE) ? hdr_fwd : out_fwd;

    // Present the FIFO head to the target, or discard it when dropping
    always_comb begin
        p_tx_o   = '0;
        p_data_o = '0;
        pop      = 1'b0;
        if (!rst_i && !empty) begin
            if (cur_fwd) begin
                p_tx_o[cur_dst]   = 1'b1;
                p_data_o[cur_dst] = head;
                pop               = p_credit_i[cur_dst];
            end else begin
                pop = 1'b1;
            end
        end
    end

    // Outbound packet FSM: latch destination, count flits, flag drops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_state <= IDLE;
            out_dst   <= '0;
            out_fwd   <= 1'b0;
            out_cnt   <= '0;
            drop_o    <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            unique case (out_state)
                IDLE: begin
                    if (pop) begin
                        out_dst   <= hdr_idx;
                        out_fwd   <= hdr_fwd;
                        out_state <= SIZE;
                    end
                end
                SIZE: begin
                    if (pop) begin
                        out_cnt <= head;
                        if (head == '0) begin
                            out_state <= IDLE;
                            drop_o    <= !out_fwd;
                        end else begin
                            out_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (pop) begin
                        out_cnt <= out_cnt - 1'b1;
                        if (out_cnt == ONE) begin
                            out_state <= IDLE;
                            drop_o    <= !out_fwd;
                        end
                    end
                end
                default: out_state <= IDLE;
            endcase
        end
    end

`ifdef HERMES_PERIPH_MUX_STATS_EN
    logic [31:0] pkt_cnt [N_PERIPH];
    logic [31:0] drop_cnt;
    logic        in_last;

    assign in_last = in_xfer &&
        ((in_state == SIZE && noc_data_o == '0) ||
         (in_state == PAYLOAD && in_cnt == ONE));

    // Wrapping packet/drop counters with a registered read port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_PERIPH; i++) begin
                pkt_cnt[i] <= '0;
            end
            drop_cnt <= '0;
            stat_o   <= '0;
        end else begin
            if (in_last) begin
                pkt_cnt[in_grant] <= pkt_cnt[in_grant] + 1'b1;
            end
            if (drop_o) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (int'(stat_sel_i) < N_PERIPH) begin
                stat_o <= pkt_cnt[stat_sel_i];
            end else begin
                stat_o <= drop_cnt;
            end
        end
    end
`endif

endmodule

// File: doc/hermes_periph_mux.md
Name: hermes_periph_mux

Overview:
- Attaches N_PERIPH packet peripherals (task injectors, future I/O) to one boundary Hermes port of a mesh PE.
- Replaces the fixed one-peripheral-per-port wiring in the many-core top.
- Mesh-bound packets: round-robin arbitration between peripherals, one whole packet at a time.
- Peripheral-bound packets: demultiplexed by a header index field, buffered in a FIFO.
- Per-channel release gating: peripherals stay invisible until the PE releases them.

Parameters:
N_PERIPH, 2, number of attached peripheral channels (1..8)
FLIT_SIZE, 32, flit width in bits
BUFFER_DEPTH, 4, depth of the mesh-to-peripheral FIFO (power of 2, >=2)
IDX_LSB, 16, LSB of the channel-index field in the header flit (field width = max(1,$clog2(N_PERIPH)))

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
release_i  in  N_PERIPH  per-channel release from PE
p_rx_i  in  N_PERIPH  peripheral flit valid
p_credit_o  out  N_PERIPH  mux accepts flit from channel
p_data_i  in  N_PERIPH x FLIT_SIZE  peripheral flit
p_tx_o  out  N_PERIPH  flit valid to peripheral
p_credit_i  in  N_PERIPH  peripheral accepts flit
p_data_o  out  N_PERIPH x FLIT_SIZE  flit to peripheral
noc_tx_o  out  1  flit valid to PE port
noc_credit_i  in  1  PE port accepts flit
noc_data_o  out  FLIT_SIZE  flit to PE port
noc_rx_i  in  1  flit valid from PE port
noc_credit_o  out  1  mux accepts flit from PE
noc_data_i  in  FLIT_SIZE  flit from PE
drop_o  out  1  one-cycle pulse when a dropped packet completes

Behaviour:
- Packet format: flit 0 = header, flit 1 = size S (payload flit count), then S payload flits.
- Transfer handshake: a flit moves when valid && credit are both high in the same cycle.
- Reset values: all outputs 0; round-robin pointer = channel 0; both FSMs IDLE; FIFO empty.
- Reset asserted mid-packet aborts the packet; no flit is emitted in the reset cycle.

Inbound FSM (peripheral to mesh): IDLE -> HEADER -> SIZE -> PAYLOAD.
- IDLE: eligible channels = p_rx_i & release_i. Round-robin grant starts at the channel after the last granted one. Grant registers in 1 cycle, then go to HEADER.
- HEADER and later: noc_tx_o = p_rx_i[g], noc_data_o = p_data_i[g], p_credit_o[g] = noc_credit_i. All other p_credit_o stay 0.
- SIZE transfer: load the counter with S. If S = 0, return to IDLE.
- PAYLOAD: decrement the counter per transfer; after the last flit, return to IDLE.
- Throughput: 1 flit/cycle inside a packet; 1 idle cycle between packets.
- release_i[g] dropping mid-packet does not abort; the packet completes. Release only masks new grants.

Outbound (mesh to peripheral):
- noc_data_i is written to the FIFO; noc_credit_o = !full.
- Full: noc_credit_o = 0, no write. Empty: no read. Simultaneous read and write at full are allowed; pointers wrap at BUFFER_DEPTH.
- Out FSM: IDLE -> SIZE -> PAYLOAD, same counting rules as inbound.
- At a header in IDLE, decode idx = header[IDX_LSB +: IDX_W].
- Forward when idx < N_PERIPH and release_i[idx] = 1: p_tx_o[idx] = !empty, read on p_credit_i[idx].
- Otherwise drop: pop 1 flit/cycle unconditionally until the packet ends, then pulse drop_o.
- The destination is latched at the header, so release changes mid-packet are ignored.
- Latency noc_rx_i -> p_tx_o: 1 cycle (registered FIFO write, combinational head read).

Optional Feature:
- Macro: HERMES_PERIPH_MUX_STATS_EN.
- When defined, adds stat_sel_i (in, IDX_W) and stat_o (out, 32).
- Per-channel 32-bit counters of completed inbound packets plus one dropped-packet counter, all wrapping.
- stat_sel_i = N_PERIPH..max reads the drop counter; stat_o is registered, 1-cycle latency.
- All counters clear on rst_i.
- When undefined: no counters and no ports; drop_o is still present.

Decomposition:
- Shared package HermesPeriphMuxPkg: FSM state enum {IDLE, HEADER, SIZE, PAYLOAD}, function computing IDX_W, header field-position constants.
- One sub-module: hermes_periph_fifo (parametric synchronous FIFO: full/empty, credit out, combinational head).
- The round-robin arbiter stays inline.

Test Plan:
- Single packet: ch0 sends header 0x0000_0101, size 3, payload A/B/C, release=11 -> 5 flits on noc_data_o in order, p_credit_o[1] = 0 throughout.
- Contention: ch0 and ch1 each hold 2 packets (size 2), both released -> grant order ch0, ch1, ch0, ch1; no interleaving inside a packet.
- Release mask: release=01, ch1 asserting rx -> ch1 never granted. Set release=11 -> ch1 granted next IDLE.
- Outbound demux: noc sends header idx=1 (0x0001_0000), size 4 -> 6 flits on p_data_o[1]. Hold p_credit_i[1] low for 10 cycles -> noc_credit_o falls after BUFFER_DEPTH=4 flits.
- Drop: header idx=1 with release=01, size 2 -> nothing on p_tx_o, drop_o pulses once after the 4th flit, next packet delivered normally.
- Size 0 plus reset: a size-0 packet returns to IDLE after 2 flits. rst_i pulsed mid-payload -> all outputs 0, FIFO empty, next packet handled cleanly.
